// File: rtl/fpu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_issue_arbiter
// Shares one multi-cycle single-precision FPU between the core issue path
// (port 0) and the logic-analyzer/debug path (port 1). Requests are
// arbitrated round-robin, and one operation at a time is launched with a start
// pulse. The arbiter then waits for the FPU done pulse under a timeout and
// returns the result on an ID-tagged response channel. The last delivered
// result is held for the mprj_io pins.
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, synchronous active-low reset
//   req_valid/req_ready [1:0]    per-port request handshake (bit0 core, bit1 debug)
//   req{0,1}_op/rm/a/b           per-port opcode, rounding mode, operands
//   fpu_start                    one-cycle launch pulse
//   fpu_op/rm/a/b                latched operation, held from ISSUE through RESP
//   fpu_done/result/flags        FPU completion
//   rsp_valid/ready              response handshake
//   rsp_id/result/flags/err      response payload (err = timeout)
//   last_result                  most recent delivered result
//   busy                         state is not IDLE
//   op_count                     completed responses, wrapping
// -----------------------------------------------------------------------------
module fpu_issue_arbiter #(
    parameter int XLEN    = 32,
    parameter int OP_W    = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [2:0]       req0_rm,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [2:0]       req1_rm,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    output logic             fpu_start,
    output logic [OP_W-1:0]  fpu_op,
    output logic [2:0]       fpu_rm,
    output logic [XLEN-1:0]  fpu_a,
    output logic [XLEN-1:0]  fpu_b,
    input  logic             fpu_done,
    input  logic [XLEN-1:0]  fpu_result,
    input  logic [4:0]       fpu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [XLEN-1:0]  rsp_result,
    output logic [4:0]       rsp_flags,
    output logic             rsp_err,
    output logic [XLEN-1:0]  last_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    // The counter only has to reach TIMEOUT-2. WAIT then lasts TIMEOUT-1
    // cycles, so the error response appears TIMEOUT cycles after the start pulse.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 2);
    localparam logic [XLEN-1:0] QNAN     = XLEN'(32'h7FC0_0000);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            last_grant_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic            grant_s;
    logic [1:0]      ready_s;
    logic            accept_s;
    logic            tmo_hit_s;

    // Round-robin winner selection; req_ready is offered only in IDLE and out of reset
    always_comb begin
        grant_s = 1'b0;
        ready_s = 2'b00;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_grant_r;
            default: grant_s = 1'b0;
        endcase
        if (wb_rst_ni && (state_r == ST_IDLE) && (req_valid != 2'b00)) begin
            ready_s = grant_s ? 2'b10 : 2'b01;
        end else begin
            ready_s = 2'b00;
        end
    end

    assign accept_s  = (ready_s != 2'b00);
    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

    // Next-state logic; done has priority over the timeout in WAIT
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_ISSUE;
                else          state_s = ST_IDLE;
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (fpu_done || tmo_hit_s) state_s = ST_RESP;
                else                       state_s = ST_WAIT;
            end
            ST_RESP: begin
                if (rsp_ready) state_s = ST_IDLE;
                else           state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus the operation, response and statistics datapath
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            tmo_cnt_r    <= '0;
            fpu_op       <= '0;
            fpu_rm       <= 3'd0;
            fpu_a        <= '0;
            fpu_b        <= '0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= 5'd0;
            rsp_err      <= 1'b0;
            last_result  <= '0;
            op_count     <= '0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        fpu_op <= grant_s ? req1_op : req0_op;
                        fpu_rm <= grant_s ? req1_rm : req0_rm;
                        fpu_a  <= grant_s ? req1_a  : req0_a;
                        fpu_b  <= grant_s ? req1_b  : req0_b;
                        rsp_id <= grant_s;
                    end
                end
                ST_ISSUE: tmo_cnt_r <= '0;
                ST_WAIT: begin
                    if (fpu_done) begin
                        rsp_result <= fpu_result;
                        rsp_flags  <= fpu_flags;
                        rsp_err    <= 1'b0;
                    end else if (tmo_hit_s) begin
                        rsp_result <= QNAN;
                        rsp_flags  <= 5'd0;
                        rsp_err    <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        last_grant_r <= rsp_id;
                        last_result  <= rsp_result;
                        op_count     <= op_count + CNT_W'(1);
                    end
                end
                default: tmo_cnt_r <= '0;
            endcase
        end
    end

    assign req_ready = ready_s;
    assign fpu_start = (state_r == ST_ISSUE);
    assign rsp_valid = (state_r == ST_RESP);
    assign busy      = (state_r != ST_IDLE);

endmodule
